// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-control and instruction-memory signals of the program-counter generator
interface pc_gen_if #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 6,
  parameter int CNT_W   = 16
);
  logic [STALL_W-1:0] stall;
  logic               if_ready;
  logic               branch_flag;
  logic [ADDR_W-1:0]  branch_target;
  logic               flush;
  logic [ADDR_W-1:0]  new_pc;
  logic [ADDR_W-1:0]  pc;
  logic               ce;
  logic               redir_pend;
  logic [CNT_W-1:0]   fetch_cnt;
  modport master (
    input  stall, if_ready, branch_flag, branch_target, flush, new_pc,
    output pc, ce, redir_pend, fetch_cnt
  );
  modport slave (
    output stall, if_ready, branch_flag, branch_target, flush, new_pc,
    input  pc, ce, redir_pend, fetch_cnt
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: fetch-address generator with stall/accept handshake and queued branch/flush redirects
module pc_gen #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          STEP      = 4,
  parameter int          STALL_W   = 6,
  parameter int          CNT_W     = 16
) (
  input logic       clk,
  input logic       rst,
  pc_gen_if.master  bus
);
  localparam logic [ADDR_W-1:0] RV = RESET_VEC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] ST = ADDR_W'(STEP);
  typedef enum logic [1:0] {IDLE, RUN, REDIR} state_t;
  state_t            state, state_n;
  logic [ADDR_W-1:0] pend_addr, pend_n, pc_n;
  logic [CNT_W-1:0]  cnt_n;
  logic              acc;
  assign acc = bus.ce & bus.if_ready & ~bus.stall[0];
  // state and holding registers; ce rises on the first edge out of reset and stays up
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bus.pc         <= RV;
      bus.ce         <= 1'b0;
      bus.redir_pend <= 1'b0;
      pend_addr      <= '0;
      bus.fetch_cnt  <= '0;
    end else begin
      state          <= state_n;
      bus.pc         <= pc_n;
      bus.ce         <= 1'b1;
      bus.redir_pend <= state_n == REDIR;
      pend_addr      <= pend_n;
      bus.fetch_cnt  <= cnt_n;
    end
  end
  // next state: a branch that cannot be accepted parks in REDIR until the next accept or flush
  always_comb begin
    state_n = state == IDLE ? RUN :
              bus.flush     ? RUN :
              bus.branch_flag ? (acc ? RUN : REDIR) :
              acc           ? RUN : state;
  end
  // next pc, queued target and saturating accept counter; flush beats branch beats accept
  always_comb begin
    pc_n   = state == IDLE     ? (bus.flush ? bus.new_pc : bus.pc) :
             bus.flush         ? bus.new_pc :
             bus.branch_flag   ? (acc ? bus.branch_target : bus.pc) :
             acc               ? (state == REDIR ? pend_addr : bus.pc + ST) : bus.pc;
    pend_n = state != IDLE && !bus.flush && bus.branch_flag && !acc ? bus.branch_target : pend_addr;
    cnt_n  = acc && !(&bus.fetch_cnt) ? bus.fetch_cnt + 1'b1 : bus.fetch_cnt;
  end
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the instruction-fetch stage, superseding the fixed 32-bit free-running PC. It issues fetch addresses on a request/accept handshake with instruction memory and honours pipeline stalls. It accepts branch redirects and flush redirects (exception/eret), and queues a redirect that arrives while the fetch cannot advance. It sits between the pipeline control unit and the instruction ROM/IF-ID register.

## Interface
- ADDR_W, 32, PC width in bits (≥ 8)
- RESET_VEC, 32'h0000_0000, first fetch address after reset (low ADDR_W bits used)
- STEP, 4, sequential increment in bytes
- STALL_W, 6, width of pipeline stall vector
- CNT_W, 16, width of accepted-fetch counter
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  STALL_W  stall vector from control; only stall[0] (PC stage hold) is used here
- if_ready  in  1  instruction memory accepts the current pc this cycle
- branch_flag  in  1  branch taken, redirect to branch_target
- branch_target  in  ADDR_W  branch destination
- flush  in  1  pipeline flush, redirect to new_pc unconditionally
- new_pc  in  ADDR_W  flush/exception destination
- pc  out  ADDR_W  current fetch address (registered)
- ce  out  1  fetch request / chip enable (registered)
- redir_pend  out  1  a redirect is queued and not yet applied
- fetch_cnt  out  CNT_W  number of accepted fetches since reset, saturating

## Operation
- Accept event: acc = ce & if_ready & ~stall[0], combinational from registered ce and inputs.
- State register: IDLE, RUN, REDIR. Holding registers: pend_addr (ADDR_W), fetch_cnt.
- Reset: state=IDLE, pc=RESET_VEC, ce=0, redir_pend=0, pend_addr=0, fetch_cnt=0.
- IDLE: on the first edge with rst low, ce<=1 and state<=RUN. pc keeps RESET_VEC, unless flush=1, in which case pc<=new_pc. branch_flag is ignored in IDLE.
- RUN / REDIR priority per edge: flush > branch_flag > acc > hold.
  - flush=1: pc<=new_pc, redir_pend<=0, state<=RUN. This applies regardless of stall[0], if_ready or a queued redirect.
  - branch_flag=1 with acc=1: pc<=branch_target, redir_pend<=0, state<=RUN.
  - branch_flag=1 with acc=0: pend_addr<=branch_target, redir_pend<=1, state<=REDIR, pc held. A newer branch overwrites an older queued one.
  - No redirect with acc=1 in RUN: pc<=pc+STEP.
  - No redirect with acc=1 in REDIR: pc<=pend_addr, redir_pend<=0, state<=RUN.
  - acc=0 and no redirect: pc and state held.
- Arithmetic: pc+STEP is modulo 2^ADDR_W, so it wraps to 0 with no flag. Targets are loaded verbatim, with no alignment forcing.
- fetch_cnt increments on every edge where acc=1. It saturates at 2^CNT_W−1 and is cleared only by rst.
- ce stays 1 in RUN and REDIR. It drops only on rst.

## Timing
- Latency: one cycle from rst deassertion to ce=1, with pc=RESET_VEC presented on that cycle.
- A redirect input sampled at edge N appears on pc after edge N, i.e. in cycle N+1. A queued redirect appears the cycle after the first acc.
- pc is stable while acc=0 and no redirect occurs; memory may sample pc any cycle ce=1.
- rst asserted mid-operation (including REDIR) returns all outputs to reset values after that edge and discards the queued redirect.
- Simultaneous flush and branch_flag: the flush wins and the branch is dropped.
- Simultaneous branch_flag and acc while in REDIR: the new branch_target wins and pend_addr is discarded.

## Test plan
- Reset release: rst high 3 cycles then low, if_ready=1, stall=0 -> cycle 1: ce=1, pc=0x0. Following cycles: pc=0x4, 0x8, 0xC. fetch_cnt=3 after the third accept.
- Stall/backpressure: stall[0]=1 for 2 cycles at pc=0x10, then if_ready=0 for 1 cycle -> pc holds 0x10 for 3 cycles, then 0x14. fetch_cnt does not increment while held.
- Queued branch: stall[0]=1, branch_flag=1, branch_target=0x100 for one cycle at pc=0x20 -> redir_pend=1, pc=0x20. Release stall -> the next pc is 0x100, redir_pend=0, and the following pc is 0x104.
- Flush priority: flush=1, new_pc=0x180, branch_flag=1, branch_target=0x200, stall[0]=1 -> next pc=0x180, redir_pend=0, branch dropped.
- Wrap and saturation (ADDR_W=8, CNT_W=4, RESET_VEC=0xF8): free run -> pc 0xF8, 0xFC, 0x00, 0x04. fetch_cnt stops at 15 after 15+ accepts.
- Reset mid-REDIR: queue a branch to 0x300, then assert rst one cycle -> pc=RESET_VEC, ce=0, redir_pend=0, fetch_cnt=0. After release, fetch resumes from RESET_VEC, not 0x300.
